// File: rtl/axi_line_master_pkg.sv
// Shared types and AXI constants for the cache-line AXI4 master.
package axi_line_master_pkg;

    typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA, R_RESP} rd_state_t;
    typedef enum logic [1:0] {W_IDLE, W_REQ, W_B, W_RESP} wr_state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_8B    = 3'd3;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    // Round a byte address down to the start of its cache line (8-byte beats).
    function automatic logic [31:0] line_align(input logic [31:0] addr, input int beats);
        return addr & ~(32'(beats * 8) - 32'd1);
    endfunction

endpackage

// File: rtl/axi_line_rd_fsm.sv
// Read path: turns one refill request into an INCR burst and assembles the beats into a line.
module axi_line_rd_fsm
    import axi_line_master_pkg::*;
#(
    parameter int         LINE_BEATS = 4,
    parameter logic [3:0] RD_ID      = 4'd0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     rd_req_valid,
    output logic                     rd_req_ready,
    input  logic [31:0]              rd_req_addr,
    output logic                     rd_resp_valid,
    output logic [64*LINE_BEATS-1:0] rd_resp_data,
    output logic                     rd_resp_err,
    output logic                     arvalid,
    input  logic                     arready,
    output logic [31:0]              araddr,
    output logic [3:0]               arid,
    output logic [7:0]               arlen,
    output logic [2:0]               arsize,
    output logic [1:0]               arburst,
    input  logic                     rvalid,
    output logic                     rready,
    input  logic [3:0]               rid,
    input  logic [63:0]              rdata,
    input  logic [1:0]               rresp,
    input  logic                     rlast
);

    localparam int               CNT_W    = $clog2(LINE_BEATS) + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LINE_BEATS - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(LINE_BEATS);

    rd_state_t               state_q, state_d;
    logic [31:0]             addr_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    err_q;
    logic [64*LINE_BEATS-1:0] line_q;
    logic                    beat;

    always_ff @(posedge clock) begin
        if (reset) state_q <= R_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            R_IDLE:  if (rd_req_valid)     state_d = R_AR;
            R_AR:    if (arready)          state_d = R_DATA;
            R_DATA:  if (rvalid && rlast)  state_d = R_RESP;
            R_RESP:                        state_d = R_IDLE;
            default:                       state_d = R_IDLE;
        endcase
    end

    assign beat = (state_q == R_DATA) && rvalid;

    // NOTE: the line buffer is reset along with the control state because rd_resp_data is visible to the client.
    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
            line_q <= '0;
        end else begin
            if (state_q == R_IDLE && rd_req_valid) begin
                addr_q <= line_align(rd_req_addr, LINE_BEATS);
                cnt_q  <= '0;
                err_q  <= 1'b0;
            end
            if (beat) begin
                // Overrun beats match no slot and leave the counter saturated, so they are dropped.
                for (int i = 0; i < LINE_BEATS; i++)
                    if (cnt_q == CNT_W'(i)) line_q[64*i +: 64] <= rdata;
                if (cnt_q != CNT_SAT) cnt_q <= cnt_q + CNT_W'(1);
                err_q <= err_q | (rresp != AXI_RESP_OKAY) | (rid != RD_ID)
                               | (rlast && (cnt_q != LAST_IDX));
            end
        end
    end

    // NOTE: handshake outputs are forced to their idle values while reset is high, not just after the edge.
    assign rd_req_ready  = (state_q == R_IDLE) || reset;
    assign arvalid       = (state_q == R_AR)   && !reset;
    assign rready        = (state_q == R_DATA) && !reset;
    assign rd_resp_valid = (state_q == R_RESP) && !reset;

    assign rd_resp_data = line_q;
    assign rd_resp_err  = err_q;
    assign araddr       = addr_q;
    assign arid         = RD_ID;
    assign arlen        = 8'(LINE_BEATS - 1);
    assign arsize       = AXI_SIZE_8B;
    assign arburst      = AXI_BURST_INCR;

endmodule

// File: rtl/axi_line_master.sv
// AXI4 master bridge: line-refill read bursts and single-beat stores, on independent paths.
module axi_line_master
    import axi_line_master_pkg::*;
#(
    parameter int         LINE_BEATS = 4,
    parameter logic [3:0] RD_ID      = 4'd0,
    parameter logic [3:0] WR_ID      = 4'd1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     rd_req_valid,
    output logic                     rd_req_ready,
    input  logic [31:0]              rd_req_addr,
    output logic                     rd_resp_valid,
    output logic [64*LINE_BEATS-1:0] rd_resp_data,
    output logic                     rd_resp_err,
    input  logic                     wr_req_valid,
    output logic                     wr_req_ready,
    input  logic [31:0]              wr_req_addr,
    input  logic [63:0]              wr_req_data,
    input  logic [7:0]               wr_req_strb,
    output logic                     wr_resp_valid,
    output logic                     wr_resp_err,
    output logic                     arvalid,
    input  logic                     arready,
    output logic [31:0]              araddr,
    output logic [3:0]               arid,
    output logic [7:0]               arlen,
    output logic [2:0]               arsize,
    output logic [1:0]               arburst,
    output logic [1:0]               arlock,
    output logic [3:0]               arcache,
    output logic [2:0]               arprot,
    input  logic                     rvalid,
    output logic                     rready,
    input  logic [3:0]               rid,
    input  logic [63:0]              rdata,
    input  logic [1:0]               rresp,
    input  logic                     rlast,
    output logic                     awvalid,
    input  logic                     awready,
    output logic [31:0]              awaddr,
    output logic [3:0]               awid,
    output logic [7:0]               awlen,
    output logic [2:0]               awsize,
    output logic [1:0]               awburst,
    output logic [1:0]               awlock,
    output logic [3:0]               awcache,
    output logic [2:0]               awprot,
    output logic                     wvalid,
    input  logic                     wready,
    output logic [3:0]               wid,
    output logic [63:0]              wdata,
    output logic [7:0]               wstrb,
    output logic                     wlast,
    input  logic                     bvalid,
    output logic                     bready,
    input  logic [3:0]               bid,
    input  logic [1:0]               bresp
);

    axi_line_rd_fsm #(.LINE_BEATS(LINE_BEATS), .RD_ID(RD_ID)) u_rd (
        .clock(clock), .reset(reset),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
        .rd_resp_valid(rd_resp_valid), .rd_resp_data(rd_resp_data), .rd_resp_err(rd_resp_err),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
        .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast)
    );

    wr_state_t   wr_state_q, wr_state_d;
    logic        aw_done_q, w_done_q, wr_err_q;
    logic [31:0] wr_addr_q;
    logic [63:0] wr_data_q;
    logic [7:0]  wr_strb_q;
    logic        aw_hs, w_hs;

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;

    always_ff @(posedge clock) begin
        if (reset) wr_state_q <= W_IDLE;
        else       wr_state_q <= wr_state_d;
    end

    always_comb begin
        wr_state_d = wr_state_q;
        case (wr_state_q)
            W_IDLE: if (wr_req_valid) wr_state_d = W_REQ;
            W_REQ:  if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) wr_state_d = W_B;
            W_B:    if (bvalid) wr_state_d = W_RESP;
            W_RESP: wr_state_d = W_IDLE;
            default: wr_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            wr_err_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_strb_q <= '0;
        end else begin
            if (wr_state_q == W_IDLE && wr_req_valid) begin
                wr_addr_q <= wr_req_addr;
                wr_data_q <= wr_req_data;
                wr_strb_q <= wr_req_strb;
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
            end
            if (aw_hs) aw_done_q <= 1'b1;
            if (w_hs)  w_done_q  <= 1'b1;
            if (wr_state_q == W_B && bvalid)
                wr_err_q <= (bresp != AXI_RESP_OKAY) || (bid != WR_ID);
        end
    end

    // AW and W rise together; each drops once its own channel has handshaken.
    assign wr_req_ready  = (wr_state_q == W_IDLE) || reset;
    assign awvalid       = (wr_state_q == W_REQ) && !aw_done_q && !reset;
    assign wvalid        = (wr_state_q == W_REQ) && !w_done_q && !reset;
    assign bready        = (wr_state_q == W_B) && !reset;
    assign wr_resp_valid = (wr_state_q == W_RESP) && !reset;
    assign wr_resp_err   = wr_err_q;

    assign awaddr  = wr_addr_q;
    assign awid    = WR_ID;
    assign awlen   = 8'd0;
    assign awsize  = AXI_SIZE_8B;
    assign awburst = AXI_BURST_INCR;
    assign wid     = WR_ID;
    assign wdata   = wr_data_q;
    assign wstrb   = wr_strb_q;
    assign wlast   = 1'b1;

    assign arlock  = '0;
    assign arcache = '0;
    assign arprot  = '0;
    assign awlock  = '0;
    assign awcache = '0;
    assign awprot  = '0;

endmodule
